// File: rtl/alu_if.sv
// Operand/control bundle into the execute-stage ALU plus its registered result.
// Latency: none (wiring only); the result side is driven by the ALU register.
// Backpressure: none; a new control word may be presented every cycle.
interface alu_if;
  logic [17:0] Op_in;   // [17] reserved, [16] result enable, [15:0] one-hot select
  logic [31:0] input1;  // operand A
  logic [31:0] input2;  // operand B, [4:0] doubles as shift amount
  logic [31:0] out_32;  // registered result

  modport master (output Op_in, output input1, output input2, input out_32);
  modport slave  (input Op_in, input input1, input input2, output out_32);
endinterface

// File: rtl/alu.sv
// 32-bit execute-stage ALU: 16 one-hot-selected operations, lowest set bit wins.
// Latency: 1 cycle; the result is captured on the rising edge when Op_in[16] is set.
// Backpressure: none; one operation is accepted per cycle, with no handshake.
module alu (
  input  logic clk,
  input  logic reset,
  alu_if.slave bus
);

  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [4:0]  w_shamt;
  logic [15:0] w_sel;
  logic        w_en;
  logic [31:0] w_ops [16];
  logic [31:0] w_result;
  logic [31:0] r_out;

  // The reserved control bit is deliberately ignored.
  logic        w_unused_reserved;

  assign w_a               = bus.input1;
  assign w_b               = bus.input2;
  assign w_shamt           = bus.input2[4:0];
  assign w_sel             = bus.Op_in[15:0];
  assign w_en              = bus.Op_in[16];
  assign w_unused_reserved = bus.Op_in[17];

  // Compute every candidate result in parallel; the selector picks one below.
  always_comb begin
    w_ops[0]  = w_a + w_b;
    w_ops[1]  = w_a - w_b;
    w_ops[2]  = w_a & w_b;
    w_ops[3]  = w_a | w_b;
    w_ops[4]  = w_a ^ w_b;
    w_ops[5]  = ~(w_a | w_b);
    w_ops[6]  = {31'b0, ($signed(w_a) < $signed(w_b))};
    w_ops[7]  = {31'b0, (w_a < w_b)};
    w_ops[8]  = w_a << w_shamt;
    w_ops[9]  = w_a >> w_shamt;
    w_ops[10] = $unsigned($signed(w_a) >>> w_shamt);
    w_ops[11] = {w_b[15:0], 16'h0000};
    w_ops[12] = w_a * w_b;
    w_ops[13] = w_a;
    w_ops[14] = w_b;
    w_ops[15] = ~w_a;
  end

  // Priority select: scanning from the top down lets the lowest set bit
  // overwrite higher ones; an all-zero select leaves the result at zero.
  always_comb begin
    w_result = 32'h0000_0000;
    for (int i = 15; i >= 0; i--) begin
      if (w_sel[i]) begin
        w_result = w_ops[i];
      end
    end
  end

  // Result register: reset beats enable, otherwise hold when not enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out <= 32'h0000_0000;
    end else if (w_en) begin
      r_out <= w_result;
    end
  end

  assign bus.out_32 = r_out;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the ALU: directed cases plus randomized traffic.
// Latency: expects each enabled result on out_32 one edge after it is driven.
// Backpressure: none to model; stimulus changes every cycle.
module tb_alu;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] exp_out;

  alu_if u_if ();

  alu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: find the lowest set select bit, then apply that operation.
  function automatic logic [31:0] ref_result(input logic [17:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    int sel;
    int unsigned sh;
    logic [63:0] prod;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sel  = -1;
    sh   = b % 32;
    sa   = a;
    sb   = b;
    prod = {32'h0, a} * {32'h0, b};
    for (int i = 0; i < 16; i++) begin
      if (op[i] && sel < 0) sel = i;
    end
    case (sel)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return ~(a | b);
      6:  return (sa < sb) ? 32'd1 : 32'd0;
      7:  return (a < b) ? 32'd1 : 32'd0;
      8:  return a << sh;
      9:  return a >> sh;
      10: return sa >>> sh;
      11: return {b[15:0], 16'h0000};
      12: return prod[31:0];
      13: return a;
      14: return b;
      15: return ~a;
      default: return 32'h0;
    endcase
  endfunction

  // Drive one cycle of inputs, let one rising edge pass, settle past it,
  // and advance the expected register according to the timing rules.
  task automatic step(input logic [17:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic rst);
    u_if.Op_in  = op;
    u_if.input1 = a;
    u_if.input2 = b;
    reset       = rst;
    @(posedge clk);
    #1;
    if (rst)        exp_out = 32'h0;
    else if (op[16]) exp_out = ref_result(op, a, b);
  endtask

  task automatic test_reset();
    step(18'h10001, 32'h1234, 32'h5678, 1'b1);
    checks++;
    if (u_if.out_32 !== 32'h0) begin
      errors++;
      $display("FAIL reset_state got %h want %h", u_if.out_32, 32'h0);
    end
  endtask

  task automatic test_arith();
    logic [17:0] ops [6];
    logic [31:0] as  [6];
    logic [31:0] bs  [6];
    logic [31:0] wants [6];
    ops = '{18'h10001, 18'h10002, 18'h10001, 18'h10040, 18'h10080, 18'h10400};
    as  = '{32'h4, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    bs  = '{32'h10, 32'h1, 32'h1, 32'h1, 32'h1, 32'h24};
    wants = '{32'h14, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h0, 32'hF800_0000};
    for (int i = 0; i < 6; i++) begin
      step(ops[i], as[i], bs[i], 1'b0);
      checks++;
      if (u_if.out_32 !== wants[i]) begin
        errors++;
        $display("FAIL arith_%0d got %h want %h", i, u_if.out_32, wants[i]);
      end
    end
    step(18'h10200, 32'h8000_0000, 32'h24, 1'b0);
    checks++;
    if (u_if.out_32 !== 32'h0800_0000) begin
      errors++;
      $display("FAIL srl got %h want %h", u_if.out_32, 32'h0800_0000);
    end
  endtask

  task automatic test_hold_priority();
    step(18'h10001, 32'h4, 32'h10, 1'b0);
    step(18'h00002, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
    checks++;
    if (u_if.out_32 !== 32'h14) begin
      errors++;
      $display("FAIL hold got %h want %h", u_if.out_32, 32'h14);
    end
    step(18'h10006, 32'd5, 32'd3, 1'b0);
    checks++;
    if (u_if.out_32 !== 32'h2) begin
      errors++;
      $display("FAIL priority got %h want %h", u_if.out_32, 32'h2);
    end
    step(18'h30000, 32'd5, 32'd3, 1'b0);
    checks++;
    if (u_if.out_32 !== 32'h0) begin
      errors++;
      $display("FAIL no_select got %h want %h", u_if.out_32, 32'h0);
    end
    // Reserved bit set must not alter an otherwise identical operation.
    step(18'h32000, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0);
    checks++;
    if (u_if.out_32 !== 32'hFFFF_0000) begin
      errors++;
      $display("FAIL reserved_bit got %h want %h", u_if.out_32, 32'hFFFF_0000);
    end
  endtask

  task automatic test_reset_priority();
    step(18'h10001, 32'h7, 32'h8, 1'b0);
    step(18'h10001, 32'h7, 32'h8, 1'b1);
    checks++;
    if (u_if.out_32 !== 32'h0) begin
      errors++;
      $display("FAIL reset_wins got %h want %h", u_if.out_32, 32'h0);
    end
    step(18'h10001, 32'h7, 32'h8, 1'b0);
    checks++;
    if (u_if.out_32 !== 32'hF) begin
      errors++;
      $display("FAIL after_reset got %h want %h", u_if.out_32, 32'hF);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 16; i++) begin
      op = 18'h10000 | (18'h1 << i);
      a  = $urandom;
      b  = $urandom;
      step(op, a, b, 1'b0);
      checks++;
      if (u_if.out_32 !== exp_out) begin
        errors++;
        $display("FAIL b2b_op%0d a=%h b=%h got %h want %h", i, a, b, u_if.out_32, exp_out);
      end
    end
  endtask

  task automatic test_random();
    logic [17:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic rst;
    for (int i = 0; i < 400; i++) begin
      op[15:0] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : (16'h1 << $urandom_range(0, 15));
      op[16]   = ($urandom_range(0, 3) != 0);
      op[17]   = 1'($urandom);
      a        = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      b        = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      rst      = ($urandom_range(0, 31) == 0);
      step(op, a, b, rst);
      checks++;
      if (u_if.out_32 !== exp_out) begin
        errors++;
        $display("FAIL random_%0d op=%h a=%h b=%h rst=%b got %h want %h",
                 i, op, a, b, rst, u_if.out_32, exp_out);
      end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    exp_out     = 32'h0;
    reset       = 1'b0;
    u_if.Op_in  = 18'h0;
    u_if.input1 = 32'h0;
    u_if.input2 = 32'h0;
    @(negedge clk);
    test_reset();
    test_arith();
    test_hold_priority();
    test_reset_priority();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

32-bit combinational-operation ALU with a registered result, used as the execute-stage arithmetic unit of the CMPE200 datapath. It takes an 18-bit control word and two 32-bit operands. It selects one of 16 operations by a one-hot field and latches the result into `out_32` on the rising clock edge when the enable bit is set.

## Interface
- No parameters; all widths fixed.
- `clk`  input  1  — single clock; all state updates on the rising edge.
- `reset`  input  1  — synchronous, active-high; clears `out_32`.
- `Op_in`  input  18  — control word: `[17]` reserved (ignored), `[16]` result enable, `[15:0]` one-hot operation select.
- `input1`  input  32  — operand A.
- `input2`  input  32  — operand B; `[4:0]` is the shift amount for shift operations.
- `out_32`  output  32  — registered result.

## Operation
- Operation select (`Op_in` bit → function):
  - 0 ADD: A+B
  - 1 SUB: A−B
  - 2 AND: A&B
  - 3 OR: A|B
  - 4 XOR: A^B
  - 5 NOR: ~(A|B)
  - 6 SLT: signed A<B ? 1 : 0
  - 7 SLTU: unsigned A<B ? 1 : 0
  - 8 SLL: A << B[4:0]
  - 9 SRL: A >> B[4:0], logical
  - 10 SRA: A >>> B[4:0], arithmetic, sign-filled
  - 11 LUI: {B[15:0], 16'h0000}
  - 12 MUL: low 32 bits of unsigned A×B
  - 13 PASSA: A
  - 14 PASSB: B
  - 15 NOTA: ~A
- Multiple select bits set: lowest-numbered set bit wins (priority encode from bit 0).
- No select bit set: result is 32'h0000_0000.
- All arithmetic is modulo 2^32, with silent wrap-around. There are no carry, overflow or zero flags.
- Shift amounts use only `input2[4:0]`; `input2[31:5]` is ignored for shifts. A shift amount of 0 passes A unchanged.
- `Op_in[17]` has no effect on any output.

## Timing
- Next-state logic, evaluated at each rising `clk` edge:
  - `reset`=1: `out_32` ← 0, regardless of `Op_in`.
  - Otherwise, `Op_in[16]`=1: `out_32` ← result computed from the current `Op_in`, `input1` and `input2`.
  - Otherwise: `out_32` holds its previous value.
- Latency is 1 cycle: operands presented before edge N appear on `out_32` after edge N.
- One new result per cycle is accepted; there is no handshake and no back-pressure.
- Reset value of `out_32` is 32'h0. Before the first reset, `out_32` is unspecified (X in simulation).
- A reset asserted in the same cycle as an enabled operation takes priority; that result is discarded.
- Inputs may change every cycle. Only values present at the sampling edge matter.

## Test plan
- Reset, then drive `Op_in`=18'h10001 (ADD), `input1`=32'h4, `input2`=32'h10 → `out_32`=32'h0000_0014 after the next edge.
- Drive SUB (18'h10002) with A=32'h0, B=32'h1 → 32'hFFFF_FFFF. Then ADD with A=32'hFFFF_FFFF, B=32'h1 → 32'h0 (wrap).
- SLT (18'h10040) with A=32'hFFFF_FFFF, B=32'h1 → 32'h1. SLTU (18'h10080) with the same operands → 32'h0.
- SRA (18'h10400) with A=32'h8000_0000, B=32'h0000_0024 (shift amount 4) → 32'hF800_0000. SRL (18'h10200) with the same operands → 32'h0800_0000.
- Hold and priority:
  - Load 32'h14 via ADD.
  - Then drive `Op_in`=18'h00002 (enable clear) with any operands → `out_32` stays 32'h14.
  - Then drive `Op_in`=18'h10006 with A=5, B=3 → SUB wins, 32'h2.
  - Then drive `Op_in`=18'h10000 → 32'h0.
- Load a nonzero result, then assert `reset` together with an enabled ADD → `out_32`=32'h0 after the edge. Release `reset` → the next enabled op loads normally.
